// File: rtl/stage3_pack_ctrl.sv
// Packs left-justified variable-length codes (0..72 bits) into 64-bit MSB-first words; flushes a zero-padded tail on block end.
// Latency: a beat that completes a word raises o_valid on the next cycle; o_done is a registered pulse one cycle after the final transfer.
// Backpressure: o_ready depends only on registered state; the output word is held stable while o_valid && !i_ready.
module stage3_pack_ctrl #(
    parameter int WIDTH   = 136,
    parameter int CODE_W  = 72,
    parameter int O_WIDTH = 64,
    parameter int AMT_W   = 7
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CODE_W-1:0]  i_code,
    input  logic [AMT_W-1:0]   i_len,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [O_WIDTH-1:0] o_word,
    output logic               o_last,
    output logic [AMT_W-1:0]   o_last_bits,
    output logic               o_done,
    output logic               o_err
);

    // Fill reaches 63+72=135, which needs one bit more than the length field.
    localparam int FILL_W = AMT_W + 1;
    localparam int PAD_W  = WIDTH - CODE_W;

    localparam logic [FILL_W-1:0] OW_F   = FILL_W'(O_WIDTH);
    localparam logic [AMT_W-1:0]  CODE_A = AMT_W'(CODE_W);
    localparam logic [AMT_W-1:0]  OW_A   = AMT_W'(O_WIDTH);

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   win_q, win_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               flush_pend_q, flush_pend_d;
    logic               done_q, done_d;
    logic               err_q;

    logic               fire;
    logic               len_ovf;
    logic [AMT_W-1:0]   len_c;
    logic [CODE_W-1:0]  code_m;
    logic [WIDTH-1:0]   win_app;
    logic [FILL_W-1:0]  fill_app;
    logic [WIDTH-1:0]   win_sh;
    logic [FILL_W-1:0]  fill_sub;
    logic               last_emit;

    assign len_ovf  = i_len > CODE_A;
    assign len_c    = len_ovf ? CODE_A : i_len;
    assign code_m   = i_code & ~({CODE_W{1'b1}} >> len_c);
    assign win_app  = win_q | ({code_m, {PAD_W{1'b0}}} >> fill_q);
    assign fill_app = fill_q + {1'b0, len_c};
    assign win_sh   = win_q << O_WIDTH;
    assign fill_sub = fill_q - OW_F;

    assign o_ready   = (state_q == S_FILL) && (fill_q < OW_F) && !flush_pend_q;
    assign fire      = i_valid && o_ready;
    assign last_emit = flush_pend_q && (fill_q == OW_F);
    assign o_done    = done_q;
    assign o_err     = err_q;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        fill_d       = fill_q;
        flush_pend_d = flush_pend_q;
        done_d       = 1'b0;
        o_valid      = 1'b0;
        o_word       = '0;
        o_last       = 1'b0;
        o_last_bits  = OW_A;
        case (state_q)
            S_FILL: begin
                if (fire) begin
                    // Decide from the post-append fill so a completed word is visible next cycle.
                    win_d        = win_app;
                    fill_d       = fill_app;
                    flush_pend_d = i_last;
                    if (fill_app >= OW_F) begin
                        state_d = S_EMIT;
                    end else if (i_last && (fill_app != '0)) begin
                        state_d = S_FLUSH;
                    end
                end else if (fill_q >= OW_F) begin
                    state_d = S_EMIT;
                end else if (flush_pend_q) begin
                    if (fill_q != '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        done_d       = 1'b1;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            S_EMIT: begin
                o_valid = 1'b1;
                o_word  = win_q[WIDTH-1 -: O_WIDTH];
                o_last  = last_emit;
                if (i_ready) begin
                    win_d  = win_sh;
                    fill_d = fill_sub;
                    if (fill_sub >= OW_F) begin
                        state_d = S_EMIT;
                    end else if (last_emit) begin
                        done_d       = 1'b1;
                        flush_pend_d = 1'b0;
                        state_d      = S_FILL;
                    end else if (flush_pend_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FLUSH: begin
                o_valid     = 1'b1;
                o_word      = win_q[WIDTH-1 -: O_WIDTH];
                o_last      = 1'b1;
                o_last_bits = fill_q[AMT_W-1:0];
                if (i_ready) begin
                    win_d        = '0;
                    fill_d       = '0;
                    flush_pend_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_FILL;
            win_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
            err_q        <= err_q | (fire & len_ovf);
        end
    end

endmodule
